// File: rtl/mem_op_queue.sv
// In-order load/store queue: decodes RV32I memory ops, waits for AGU/CDB
// address and data by ROB tag, and issues the oldest ready entry to memory.
module mem_op_queue #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 5,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   enq_valid,
  output logic                   enq_ready,
  input  logic [6:0]             enq_opcode,
  input  logic [2:0]             enq_funct3,
  input  logic [TAG_W-1:0]       enq_tag,
  output logic                   enq_illegal,
  input  logic                   wb_valid,
  input  logic [TAG_W-1:0]       wb_tag,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output logic                   iss_is_store,
  output logic [1:0]             iss_size,
  output logic                   iss_unsigned,
  output logic [TAG_W-1:0]       iss_tag,
  output logic [ADDR_W-1:0]      iss_addr,
  output logic [DATA_W-1:0]      iss_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic [DEPTH-1:0]  ent_valid, ent_rdy, ent_store, ent_uns;
  logic [1:0]        ent_size [DEPTH];
  logic [TAG_W-1:0]  ent_tag  [DEPTH];
  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [PW-1:0]     head, tail;

  logic       is_mem, legal, dec_store, dec_uns;
  logic [1:0] dec_size;
  logic       enq_accept, enq_fire, deq;

  // funct3[1:0] directly encodes access size for both loads and stores.
  always_comb begin
    is_mem    = 1'b0;
    legal     = 1'b0;
    dec_store = 1'b0;
    dec_uns   = 1'b0;
    dec_size  = enq_funct3[1:0];
    if (enq_opcode == OP_LOAD) begin
      is_mem  = 1'b1;
      legal   = enq_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      dec_uns = enq_funct3[2];
    end else if (enq_opcode == OP_STORE) begin
      is_mem    = 1'b1;
      dec_store = 1'b1;
      legal     = !enq_funct3[2] && (enq_funct3[1:0] != 2'b11);
    end
  end

  assign enq_ready  = (count != (PW+1)'(DEPTH));
  assign enq_accept = enq_valid && enq_ready;
  assign enq_fire   = enq_accept && is_mem && legal;
  assign deq        = iss_valid && iss_ready;

  always_comb begin
    iss_valid    = ent_valid[head] && ent_rdy[head];
    iss_is_store = 1'b0;
    iss_size     = 2'b00;
    iss_unsigned = 1'b0;
    iss_tag      = '0;
    iss_addr     = '0;
    iss_data     = '0;
    if (iss_valid) begin
      iss_is_store = ent_store[head];
      iss_size     = ent_size[head];
      iss_unsigned = ent_uns[head];
      iss_tag      = ent_tag[head];
      iss_addr     = ent_addr[head];
      iss_data     = ent_data[head];
    end
  end

  // Later writes win: a dequeue clears a head that a writeback also matched,
  // and the tail slot is always invalid so writeback never touches a new entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      enq_illegal <= 1'b0;
      ent_valid   <= '0;
      ent_rdy     <= '0;
      ent_store   <= '0;
      ent_uns     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_size[i] <= '0;
        ent_tag[i]  <= '0;
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
    end else if (flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      enq_illegal <= 1'b0;
      ent_valid   <= '0;
      ent_rdy     <= '0;
    end else begin
      enq_illegal <= enq_accept && is_mem && !legal;
      if (wb_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_valid[i] && ent_tag[i] == wb_tag) begin
            ent_addr[i] <= wb_addr;
            ent_data[i] <= wb_data;
            ent_rdy[i]  <= 1'b1;
          end
        end
      end
      if (deq) begin
        ent_valid[head] <= 1'b0;
        ent_rdy[head]   <= 1'b0;
        head            <= head + PW'(1);
      end
      if (enq_fire) begin
        ent_valid[tail] <= 1'b1;
        ent_rdy[tail]   <= 1'b0;
        ent_store[tail] <= dec_store;
        ent_uns[tail]   <= dec_uns;
        ent_size[tail]  <= dec_size;
        ent_tag[tail]   <= enq_tag;
        tail            <= tail + PW'(1);
      end
      count <= count + (PW+1)'(enq_fire) - (PW+1)'(deq);
    end
  end

endmodule
